// File: rtl/psram_access_arbiter_if.sv
// Bundle of requester, controller and status signals around psram_access_arbiter.
//   slave  : the arbiter's view (requests/controller feedback in, acks/mux/status out)
//   master : the environment's view (frame FSMs, PSRAM controller, bench)
// Signals: calib_done, wr_rq/wr_addr/wr_data/wr_cmd_en/wr_ack, rd_rq/rd_addr/rd_cmd_en/rd_ack,
//          rd_data_valid_o, mem_rd_data_valid, mem_cmd/mem_cmd_en/mem_addr/mem_wr_data, busy, err.
interface psram_access_arbiter_if;
  logic        calib_done;
  logic        wr_rq;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_cmd_en;
  logic        wr_ack;
  logic        rd_rq;
  logic [20:0] rd_addr;
  logic        rd_cmd_en;
  logic        rd_ack;
  logic        rd_data_valid_o;
  logic        mem_rd_data_valid;
  logic        mem_cmd;
  logic        mem_cmd_en;
  logic [20:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic [1:0]  err;

  modport slave (
    input  calib_done, wr_rq, wr_addr, wr_data, wr_cmd_en, rd_rq, rd_addr, rd_cmd_en,
           mem_rd_data_valid,
    output wr_ack, rd_ack, rd_data_valid_o, mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, busy,
           err
  );

  modport master (
    output calib_done, wr_rq, wr_addr, wr_data, wr_cmd_en, rd_rq, rd_addr, rd_cmd_en,
           mem_rd_data_valid,
    input  wr_ack, rd_ack, rd_data_valid_o, mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, busy,
           err
  );
endinterface

// File: rtl/psram_access_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller command port between the camera frame
// writer and the display frame reader, one burst per grant, with a turnaround gap after
// every release.
// Ports:
//   clk     : single clock
//   reset_n : synchronous active-low reset
//   bus     : psram_access_arbiter_if.slave (requests, acks, controller mux, busy, err)
// Optional feature: define ARBITER_WATCHDOG_EN to bound each grant to WATCHDOG_CYCLES cycles;
// a revoked requester must drop its request once before it can be granted again.
module psram_access_arbiter #(
  parameter int unsigned MEMORY_BURST    = 32,
  parameter int unsigned TURNAROUND      = 2,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   reset_n,
  psram_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StWaitCalib,
    StIdle,
    StGrantWr,
    StGrantRd,
    StRelease
  } state_e;

  localparam logic [3:0] TaLast = 4'(TURNAROUND - 1);

  state_e      state_q, state_d;
  logic [3:0]  ta_q, ta_d;
  logic        last_wr_q, last_wr_d;  // 1: writer was granted last
  logic        wr_ack_q, rd_ack_q, busy_q;
  logic [1:0]  err_q, err_d;
  logic        wr_elig, rd_elig;
  logic        wd_expire;
  logic        revoke;
  logic        strobe_err;

  // Burst length is fixed by the controller; kept only as documentation.
  logic unused_burst;
  assign unused_burst = ^MEMORY_BURST;

`ifdef ARBITER_WATCHDOG_EN
  localparam int unsigned    WdW    = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           blk_wr_q, blk_wr_d, blk_rd_q, blk_rd_d;

  always_comb begin
    wd_d = '0;
    // Count only while staying in the same grant; entry and exit clear the counter.
    if ((state_q == StGrantWr || state_q == StGrantRd) && state_d == state_q) begin
      wd_d = wd_q + 1'b1;
    end
    // A block lifts once the request has been sampled low.
    blk_wr_d = blk_wr_q & bus.wr_rq;
    blk_rd_d = blk_rd_q & bus.rd_rq;
    if (revoke && state_q == StGrantWr) blk_wr_d = 1'b1;
    if (revoke && state_q == StGrantRd) blk_rd_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_q     <= '0;
      blk_wr_q <= 1'b0;
      blk_rd_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      blk_wr_q <= blk_wr_d;
      blk_rd_q <= blk_rd_d;
    end
  end

  assign wd_expire = (wd_q == WdLast);
  assign wr_elig   = bus.wr_rq & ~blk_wr_q;
  assign rd_elig   = bus.rd_rq & ~blk_rd_q;
`else
  logic unused_wd;
  assign unused_wd = ^WATCHDOG_CYCLES;
  assign wd_expire = 1'b0;
  assign wr_elig   = bus.wr_rq;
  assign rd_elig   = bus.rd_rq;
`endif

  // Next state, turnaround counter and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    ta_d      = ta_q;
    last_wr_d = last_wr_q;
    revoke    = 1'b0;
    unique case (state_q)
      StWaitCalib: begin
        if (bus.calib_done) state_d = StIdle;
      end
      StIdle: begin
        if (!bus.calib_done) begin
          state_d = StWaitCalib;
        end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
          state_d   = StGrantWr;
          last_wr_d = 1'b1;
        end else if (rd_elig) begin
          state_d   = StGrantRd;
          last_wr_d = 1'b0;
        end
      end
      StGrantWr: begin
        if (!bus.wr_rq || wd_expire) begin
          state_d = StRelease;
          ta_d    = '0;
          revoke  = bus.wr_rq;
        end
      end
      StGrantRd: begin
        if (!bus.rd_rq || wd_expire) begin
          state_d = StRelease;
          ta_d    = '0;
          revoke  = bus.rd_rq;
        end
      end
      StRelease: begin
        if (ta_q == TaLast) state_d = StIdle;
        else                ta_d    = ta_q + 4'd1;
      end
      default: state_d = StWaitCalib;
    endcase
  end

  assign strobe_err = (bus.wr_cmd_en && state_q != StGrantWr) ||
                      (bus.rd_cmd_en && state_q != StGrantRd);
  assign err_d      = err_q | {revoke, strobe_err};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StWaitCalib;
      ta_q      <= '0;
      last_wr_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ta_q      <= ta_d;
      last_wr_q <= last_wr_d;
      wr_ack_q  <= (state_d == StGrantWr);
      rd_ack_q  <= (state_d == StGrantRd);
      busy_q    <= (state_d == StGrantWr) || (state_d == StGrantRd);
      err_q     <= err_d;
    end
  end

  // Controller mux: combinational from the registered state, so strobes pass with no delay.
  always_comb begin
    bus.mem_cmd         = 1'b0;
    bus.mem_cmd_en      = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wr_data     = '0;
    bus.rd_data_valid_o = 1'b0;
    unique case (state_q)
      StGrantWr: begin
        bus.mem_cmd     = 1'b1;
        bus.mem_cmd_en  = bus.wr_cmd_en;
        bus.mem_addr    = bus.wr_addr;
        bus.mem_wr_data = bus.wr_data;
      end
      StGrantRd: begin
        bus.mem_cmd_en      = bus.rd_cmd_en;
        bus.mem_addr        = bus.rd_addr;
        bus.rd_data_valid_o = bus.mem_rd_data_valid;
      end
      default: ;
    endcase
  end

  assign bus.wr_ack = wr_ack_q;
  assign bus.rd_ack = rd_ack_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Self-checking bench for psram_access_arbiter: scoreboards for grant order, forwarded
// commands and reader data-valid pulses, plus direct checks of reset, latency and err.
module tb_psram_access_arbiter;
  localparam int unsigned TA = 2;
  localparam int unsigned WD = 16;

  logic clk;
  logic reset_n;

  psram_access_arbiter_if bus ();

  psram_access_arbiter #(
    .MEMORY_BURST   (32),
    .TURNAROUND     (TA),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  byte         exp_grant[$];
  logic [53:0] exp_cmd[$];
  logic        exp_rdv[$];
  int          rdv_seen = 0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_wr);
    int k;
    k = 0;
    while (k < 30 && !(is_wr ? bus.wr_ack : bus.rd_ack)) begin
      tick(1);
      k++;
    end
    check(is_wr ? "wait_wr_ack" : "wait_rd_ack", is_wr ? bus.wr_ack : bus.rd_ack, 1);
  endtask

  // Scoreboard monitor, away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_cmd_en === 1'b1) begin
      if (exp_cmd.size() == 0) check("cmd_unexpected", bus.mem_cmd_en, 0);
      else check("cmd_fwd", {bus.mem_cmd, bus.mem_addr, bus.mem_wr_data}, exp_cmd.pop_front());
    end
    if (bus.rd_data_valid_o === 1'b1) begin
      rdv_seen++;
      if (exp_rdv.size() == 0) check("rdv_unexpected", bus.rd_data_valid_o, 0);
      else check("rdv_fwd", bus.rd_data_valid_o, exp_rdv.pop_front());
    end
    if ((bus.wr_ack === 1'b1 && !prev_wr) || (bus.rd_ack === 1'b1 && !prev_rd)) begin
      if (exp_grant.size() == 0) check("grant_unexpected", bus.wr_ack | bus.rd_ack, 0);
      else check("grant_order", bus.wr_ack ? "W" : "R", exp_grant.pop_front());
    end
    prev_wr = (bus.wr_ack === 1'b1);
    prev_rd = (bus.rd_ack === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int wcnt, rcnt, grants, gap, n;
    logic any, prev_any;

    reset_n               = 1'b0;
    bus.calib_done        = 1'b0;
    bus.wr_rq             = 1'b0;
    bus.wr_addr           = '0;
    bus.wr_data           = '0;
    bus.wr_cmd_en         = 1'b0;
    bus.rd_rq             = 1'b0;
    bus.rd_addr           = '0;
    bus.rd_cmd_en         = 1'b0;
    bus.mem_rd_data_valid = 1'b0;
    tick(3);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_rd_ack", bus.rd_ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_mem_cmd_en", bus.mem_cmd_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);

    // No grant before calibration; grant two edges after calib_done.
    reset_n   = 1'b1;
    bus.wr_rq = 1'b1;
    tick(4);
    check("no_ack_uncalib", bus.wr_ack, 0);
    exp_grant.push_back("W");
    bus.calib_done = 1'b1;
    tick(1);
    check("calib_edge1_ack", bus.wr_ack, 0);
    tick(1);
    check("calib_edge2_ack", bus.wr_ack, 1);
    check("busy_granted", bus.busy, 1);

    // Legal write strobe, then a stray read strobe.
    bus.wr_addr   = 21'h0F00D;
    bus.wr_data   = 32'hDEADBEEF;
    bus.wr_cmd_en = 1'b1;
    exp_cmd.push_back({1'b1, 21'h0F00D, 32'hDEADBEEF});
    tick(1);
    bus.wr_cmd_en = 1'b0;
    check("err_after_legal", bus.err, 2'b00);
    bus.rd_addr   = 21'h12345;
    bus.rd_cmd_en = 1'b1;
    tick(1);
    bus.rd_cmd_en = 1'b0;
    check("err_stray", bus.err, 2'b01);
    bus.wr_rq = 1'b0;
    tick(1);
    check("wr_release", bus.wr_ack, 0);
    tick(5);
    check("err_sticky", bus.err, 2'b01);

    // Both requesting continuously, 8-cycle bursts: R,W,R,W (writer granted last).
    exp_grant.push_back("R");
    exp_grant.push_back("W");
    exp_grant.push_back("R");
    exp_grant.push_back("W");
    wcnt = 0; rcnt = 0; grants = 0; gap = 0; prev_any = 1'b0;
    bus.wr_rq = 1'b1;
    bus.rd_rq = 1'b1;
    for (int cyc = 0; cyc < 300 && grants < 4; cyc++) begin
      tick(1);
      any = bus.wr_ack | bus.rd_ack;
      if (any && !prev_any) begin
        grants++;
        if (grants > 1) check("turnaround_gap", gap, TA + 1);
        gap = 0;
      end
      if (!any) gap++;
      prev_any = any;
      if (bus.wr_ack) begin
        wcnt++;
        if (wcnt == 8) begin bus.wr_rq = 1'b0; wcnt = 0; end
      end else bus.wr_rq = 1'b1;
      if (bus.rd_ack) begin
        rcnt++;
        if (rcnt == 8) begin bus.rd_rq = 1'b0; rcnt = 0; end
      end else bus.rd_rq = 1'b1;
    end
    check("alt_grants", grants, 4);
    bus.wr_rq = 1'b0;
    bus.rd_rq = 1'b0;
    tick(6);

    // Reader burst: zero-latency strobe, eight data-valid pulses.
    exp_grant.push_back("R");
    bus.rd_rq = 1'b1;
    wait_ack(0);
    bus.rd_addr   = 21'h1ABCD;
    bus.wr_data   = 32'hCAFEF00D;
    bus.rd_cmd_en = 1'b1;
    exp_cmd.push_back({1'b0, 21'h1ABCD, 32'h0});
    tick(1);
    bus.rd_cmd_en = 1'b0;
    rdv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_rd_data_valid = 1'b1;
      exp_rdv.push_back(1'b1);
      tick(1);
      bus.mem_rd_data_valid = 1'b0;
      tick(1);
    end
    check("rdv_count", rdv_seen, 8);
    check("err_unchanged", bus.err, 2'b01);
    bus.rd_rq = 1'b0;
    tick(1);
    check("rd_release", bus.rd_ack, 0);
    bus.mem_rd_data_valid = 1'b1;  // must be dropped outside the reader grant
    tick(1);
    bus.mem_rd_data_valid = 1'b0;
    tick(4);
    check("rdv_dropped", rdv_seen, 8);

    // Reset during a reader grant.
    exp_grant.push_back("R");
    bus.rd_rq = 1'b1;
    wait_ack(0);
    reset_n = 1'b0;
    tick(1);
    check("midrst_rd_ack", bus.rd_ack, 0);
    check("midrst_wr_ack", bus.wr_ack, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_busy", bus.busy, 0);
    reset_n = 1'b1;
    exp_grant.push_back("R");
    tick(1);
    check("post_rst_wait_calib", bus.rd_ack, 0);
    tick(1);
    check("post_rst_grant", bus.rd_ack, 1);
    bus.rd_rq = 1'b0;
    tick(1);

    // First tie after reset goes to the writer.
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    exp_grant.push_back("W");
    bus.wr_rq = 1'b1;
    bus.rd_rq = 1'b1;
    tick(2);
    check("tie_wr_ack", bus.wr_ack, 1);
    check("tie_rd_ack", bus.rd_ack, 0);
    bus.wr_rq = 1'b0;
    bus.rd_rq = 1'b0;
    tick(6);

`ifdef ARBITER_WATCHDOG_EN
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    exp_grant.push_back("W");
    exp_grant.push_back("R");
    bus.wr_rq = 1'b1;
    bus.rd_rq = 1'b1;
    wait_ack(1);
    n = 0;
    for (int c = 0; c < 40 && bus.wr_ack; c++) begin
      n++;
      tick(1);
    end
    check("wd_grant_len", n, WD);
    check("wd_err", bus.err, 2'b10);
    wait_ack(0);
    bus.rd_rq = 1'b0;
    tick(8);
    check("wd_wr_blocked", bus.wr_ack, 0);
    bus.wr_rq = 1'b0;
    tick(1);
    bus.wr_rq = 1'b1;
    exp_grant.push_back("W");
    wait_ack(1);
    bus.wr_rq = 1'b0;
    tick(5);
`endif

    check("grant_q_left", exp_grant.size(), 0);
    check("cmd_q_left", exp_cmd.size(), 0);
    check("rdv_q_left", exp_rdv.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
